// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Requester identity
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int unsigned WAIT_CYCLES_DEF = 4;
    localparam int unsigned CTR_W           = 8;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable 8-bit wait-state down-counter with a registered zero flag.
module mem_arb_wait_ctr
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CTR_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CTR_W-1:0] count_q, count_d;
    logic             zero_q;

    // Next count: load has priority, decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CTR_W'(1);
        end
    end

    // Count and zero-flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the main-memory port between I-cache and D-cache requesters.
// Build option: MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_strobe,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_strobe,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner_d
);

`ifndef MEM_ARB_RR_EN
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 255)) begin : g_wait_range_chk
        $error("mem_port_arbiter: WAIT_CYCLES must be within 1..255");
    end
`endif

    arb_state_e        state_q, state_d;
    req_id_e           grant_q, grant_d;
    req_id_e           win_c;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              m_strobe_q, busy_q, i_ready_q, d_ready_q;
    logic              ctr_load, ctr_en, ctr_zero;

    mem_arb_wait_ctr u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ctr_load),
        .en_i       (ctr_en),
        .load_val_i (CTR_W'(WAIT_CYCLES - 1)),
        .zero_o     (ctr_zero)
    );

    // Next-state, hold-register and read-capture logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        ctr_load  = 1'b0;
        ctr_en    = 1'b0;
        win_c     = d_strobe ? REQ_D : REQ_I;
`ifdef MEM_ARB_RR_EN
        // On contention, alternate away from the previous winner
        if (i_strobe && d_strobe) begin
            win_c = (grant_q == REQ_D) ? REQ_I : REQ_D;
        end
`endif

        case (state_q)
            IDLE: begin
                if (i_strobe || d_strobe) begin
                    grant_d = win_c;
                    state_d = GRANT;
                    if (win_c == REQ_D) begin
                        addr_d  = d_addr;
                        rw_d    = d_rw;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        rw_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            GRANT: begin
                ctr_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ctr_zero) begin
                    state_d = DONE;
                    if (grant_q == REQ_I) begin
                        i_rdata_d = m_rdata;
                    end else if (!rw_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold and registered output updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= REQ_I;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            m_strobe_q <= 1'b0;
            busy_q     <= 1'b0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            m_strobe_q <= (state_d == GRANT);
            busy_q     <= (state_d != IDLE);
            i_ready_q  <= (state_d == DONE) && (grant_d == REQ_I);
            d_ready_q  <= (state_d == DONE) && (grant_d == REQ_D);
        end
    end

    assign i_ready  = i_ready_q;
    assign i_rdata  = i_rdata_q;
    assign d_ready  = d_ready_q;
    assign d_rdata  = d_rdata_q;
    assign m_strobe = m_strobe_q;
    assign m_rw     = rw_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign busy     = busy_q;
    assign owner_d  = (grant_q == REQ_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (WAIT_CYCLES = 4).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned WC = 4;

    logic          clk;
    logic          reset;
    logic          i_strobe;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_strobe;
    logic          d_rw;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          m_strobe;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic          owner_d;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (i_strobe),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_strobe (d_strobe),
        .d_rw     (d_rw),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .m_strobe (m_strobe),
        .m_rw     (m_rw),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .busy     (busy),
        .owner_d  (owner_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed contents per address
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0040: return 32'hCAFEF00D;
            16'h0100: return 32'hDEADBEEF;
            16'h0104: return 32'h0BADC0DE;
            16'h0200: return 32'h55AA55AA;
            default:  return 32'hFFFFFFFF;
        endcase
    endfunction
    always_comb m_rdata = mem_word(m_addr);

    typedef struct {
        int unsigned cyc;
        logic [15:0] addr;
        logic        rw;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        bit          is_d;
        int unsigned cyc;
        logic [31:0] rdata;
        logic        rw;
        logic [31:0] wdata;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic fail_msg(input string nm);
        total++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic exp_m(input int unsigned c, input logic [15:0] a, input logic rw,
                         input logic [31:0] wd);
        mexp_t e;
        e.cyc = c; e.addr = a; e.rw = rw; e.wdata = wd;
        mq.push_back(e);
    endtask

    task automatic exp_r(input bit is_d, input int unsigned c, input logic [31:0] rd,
                         input logic rw, input logic [31:0] wd);
        rexp_t e;
        e.is_d = is_d; e.cyc = c; e.rdata = rd; e.rw = rw; e.wdata = wd;
        rq.push_back(e);
    endtask

    task automatic on_mstrobe();
        mexp_t e;
        if (mq.size() == 0) begin
            fail_msg("unexpected_m_strobe");
        end else begin
            e = mq.pop_front();
            check("mstrobe_cycle", 32'(cyc), 32'(e.cyc));
            check("mstrobe_addr", 32'(m_addr), 32'(e.addr));
            check("mstrobe_rw", 32'(m_rw), 32'(e.rw));
            if (e.rw) check("mstrobe_wdata", m_wdata, e.wdata);
            check("mstrobe_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic on_ready(input bit is_d);
        rexp_t e;
        if (rq.size() == 0) begin
            fail_msg(is_d ? "unexpected_d_ready" : "unexpected_i_ready");
        end else begin
            e = rq.pop_front();
            check("ready_requester", 32'(is_d), 32'(e.is_d));
            check("ready_cycle", 32'(cyc), 32'(e.cyc));
            check("ready_rdata", is_d ? d_rdata : i_rdata, e.rdata);
            check("ready_owner_d", 32'(owner_d), 32'(e.is_d));
            check("ready_busy", 32'(busy), 32'd1);
            if (e.is_d) check("ready_m_rw_held", 32'(m_rw), 32'(e.rw));
            if (e.is_d && e.rw) check("ready_m_wdata_held", m_wdata, e.wdata);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard
    always @(negedge clk) begin
        if (m_strobe === 1'b1) on_mstrobe();
        if (i_ready === 1'b1) on_ready(1'b0);
        if (d_ready === 1'b1) on_ready(1'b1);
    end

    task automatic wait_rdy(input bit is_d, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = is_d ? (d_ready === 1'b1) : (i_ready === 1'b1);
        end
        if (!seen) fail_msg({nm, "_ready_timeout"});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_m_strobe"}, 32'(m_strobe), 32'd0);
        check({tag, "_i_ready"},  32'(i_ready),  32'd0);
        check({tag, "_d_ready"},  32'(d_ready),  32'd0);
        check({tag, "_owner_d"},  32'(owner_d),  32'd0);
        check({tag, "_m_rw"},     32'(m_rw),     32'd0);
        check({tag, "_m_addr"},   32'(m_addr),   32'd0);
        check({tag, "_m_wdata"},  m_wdata,       32'd0);
        check({tag, "_i_rdata"},  i_rdata,       32'd0);
        check({tag, "_d_rdata"},  d_rdata,       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int unsigned t;

    initial begin
        reset    = 1'b1;
        i_strobe = 1'b0;
        i_addr   = '0;
        d_strobe = 1'b0;
        d_rw     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single D read
        t = cyc;
        d_strobe = 1'b1; d_rw = 1'b0; d_addr = 16'h0040;
        exp_m(t + 1, 16'h0040, 1'b0, 32'h0);
        exp_r(1'b1, t + 6, 32'hCAFEF00D, 1'b0, 32'h0);
        wait_rdy(1'b1, "d_read");
        @(posedge clk); #1;
        d_strobe = 1'b0;
        @(negedge clk);
        check("d_read_busy_after", 32'(busy), 32'd0);

        // Single D write: d_rdata must keep the previous read value
        @(posedge clk); #1;
        t = cyc;
        d_strobe = 1'b1; d_rw = 1'b1; d_addr = 16'h0080; d_wdata = 32'h12345678;
        exp_m(t + 1, 16'h0080, 1'b1, 32'h12345678);
        exp_r(1'b1, t + 6, 32'hCAFEF00D, 1'b1, 32'h12345678);
        wait_rdy(1'b1, "d_write");
        @(posedge clk); #1;
        d_strobe = 1'b0; d_rw = 1'b0;

        // Simultaneous requests; the previous grant went to D
        @(posedge clk); #1;
        t = cyc;
        d_strobe = 1'b1; d_addr = 16'h0100;
        i_strobe = 1'b1; i_addr = 16'h0104;
`ifdef MEM_ARB_RR_EN
        exp_m(t + 1, 16'h0104, 1'b0, 32'h0);
        exp_m(t + 8, 16'h0100, 1'b0, 32'h0);
        exp_r(1'b0, t + 6,  32'h0BADC0DE, 1'b0, 32'h0);
        exp_r(1'b1, t + 13, 32'hDEADBEEF, 1'b0, 32'h0);
`else
        exp_m(t + 1, 16'h0100, 1'b0, 32'h0);
        exp_m(t + 8, 16'h0104, 1'b0, 32'h0);
        exp_r(1'b1, t + 6,  32'hDEADBEEF, 1'b0, 32'h0);
        exp_r(1'b0, t + 13, 32'h0BADC0DE, 1'b0, 32'h0);
`endif
        fork
            begin
                wait_rdy(1'b1, "both_d");
                @(posedge clk); #1;
                d_strobe = 1'b0;
            end
            begin
                wait_rdy(1'b0, "both_i");
                @(posedge clk); #1;
                i_strobe = 1'b0;
            end
        join

        // Back-to-back I reads: strobe stays high into the IDLE cycle with a new address
        @(posedge clk); #1;
        t = cyc;
        i_strobe = 1'b1; i_addr = 16'h0040;
        exp_m(t + 1,  16'h0040, 1'b0, 32'h0);
        exp_m(t + 8,  16'h0100, 1'b0, 32'h0);
        exp_m(t + 15, 16'h0200, 1'b0, 32'h0);
        exp_r(1'b0, t + 6,  32'hCAFEF00D, 1'b0, 32'h0);
        exp_r(1'b0, t + 13, 32'hDEADBEEF, 1'b0, 32'h0);
        exp_r(1'b0, t + 20, 32'h55AA55AA, 1'b0, 32'h0);
        wait_rdy(1'b0, "b2b_0");
        @(posedge clk); #1;
        i_addr = 16'h0100;
        wait_rdy(1'b0, "b2b_1");
        @(posedge clk); #1;
        i_addr = 16'h0200;
        wait_rdy(1'b0, "b2b_2");
        @(posedge clk); #1;
        i_strobe = 1'b0;

        // Reset during the second WAIT cycle abandons the access
        repeat (2) @(posedge clk);
        #1;
        t = cyc;
        i_strobe = 1'b1; i_addr = 16'h0200;
        exp_m(t + 1, 16'h0200, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        i_strobe = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (8) @(posedge clk);
        #1;

        // Fresh request after the abandoned one
        t = cyc;
        i_strobe = 1'b1; i_addr = 16'h0104;
        exp_m(t + 1, 16'h0104, 1'b0, 32'h0);
        exp_r(1'b0, t + 6, 32'h0BADC0DE, 1'b0, 32'h0);
        wait_rdy(1'b0, "after_reset");
        @(posedge clk); #1;
        i_strobe = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mq_drained", 32'(mq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single main-memory port between the instruction-cache controller (read-only requester) and the data-cache controller (read/write requester). Accepts level strobes from both, grants one, and sequences the memory handshake: one-cycle memory strobe, fixed wait-state interval, then a one-cycle ready pulse and registered read data to the winner. Sits between the two cache controllers and the memory model.

Parameters:
ADDR_W, 16, address width of both requesters and the memory port
DATA_W, 32, data word width
WAIT_CYCLES, 4, memory wait states per access; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
i_strobe  in  1  I-cache request; held high until i_ready seen
i_addr  in  ADDR_W  I-cache read address
i_ready  out  1  one-cycle pulse, I-cache read complete
i_rdata  out  DATA_W  read data, valid when i_ready=1
d_strobe  in  1  D-cache request; held high until d_ready seen
d_rw  in  1  D-cache direction: 1=write, 0=read
d_addr  in  ADDR_W  D-cache address
d_wdata  in  DATA_W  D-cache write data
d_ready  out  1  one-cycle pulse, D-cache access complete
d_rdata  out  DATA_W  read data, valid when d_ready=1 and d_rw=0
m_strobe  out  1  memory strobe, one cycle per access
m_rw  out  1  memory direction: 1=write
m_addr  out  ADDR_W  memory address, held from GRANT through DONE
m_wdata  out  DATA_W  memory write data, held from GRANT through DONE
m_rdata  in  DATA_W  memory read data, valid in the last WAIT cycle
busy  out  1  high in any state other than IDLE
owner_d  out  1  1 = current or last grant went to D-cache

Behaviour:
- Reset: state IDLE; all outputs 0 (strobes, readies, busy, owner_d, m_*, rdata registers).
- States: IDLE, GRANT, WAIT, DONE.
- IDLE: if any strobe is high, latch the winner, its address, direction and write data into hold registers, then go to GRANT. Selection: d_strobe beats i_strobe (fixed priority). The I-cache request is always a read (m_rw=0).
- GRANT: m_strobe=1 for exactly one cycle; load the wait counter with WAIT_CYCLES-1; go to WAIT.
- WAIT: m_strobe=0; count down. At count==0, capture m_rdata into the winner's rdata register and go to DONE.
- DONE: winner's ready=1 for one cycle; go to IDLE. The loser's request stays pending and is considered in the next IDLE cycle.
- Latency: a strobe sampled in IDLE at cycle t gives m_strobe at t+1 and ready at t+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- Requesters deassert their strobe the cycle after ready. A strobe still high in IDLE is treated as a new request.
- Inputs are ignored outside IDLE. m_addr, m_rw and m_wdata come from the hold registers and are stable from GRANT through DONE.
- rdata registers hold their value until the next capture for that requester. On a write, d_rdata is not updated.
- Strobes that drop before ready: the access still completes, and the ready pulse is still issued.
- Reset mid-access: returns to IDLE next edge; no ready pulse; m_strobe=0; the access is abandoned.
- Both strobes high in the same IDLE cycle: D-cache is granted. The I-cache request is granted after D's DONE if it is still high.
- WAIT_CYCLES=1: WAIT lasts exactly one cycle.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. When both strobes are high in IDLE, grant the requester that did not win the previous grant (tracked by owner_d). Single requests are granted as normal.
- Undefined: fixed D-over-I priority. Sustained D-cache traffic may starve the I-cache; this is accepted.
- Undefined only: an elaboration-time assertion checks that WAIT_CYCLES is within 1..255.

Decomposition:
- Package mem_arb_pkg holds:
  - the state typedef (enum logic [1:0]: IDLE, GRANT, WAIT, DONE);
  - the requester-id typedef (REQ_I, REQ_D);
  - the constant for the default WAIT_CYCLES.
- Sub-module mem_arb_wait_ctr: loadable 8-bit down-counter with load, enable, and a zero flag. Instantiated once.

Test Plan:
- Single D read: d_strobe=1, d_rw=0, d_addr=0x0040, m_rdata=0xCAFEF00D, WAIT_CYCLES=4 -> m_strobe at t+1, d_ready at t+6, d_rdata=0xCAFEF00D, busy high for t+1..t+6.
- Single D write: d_rw=1, d_wdata=0x12345678 -> m_rw=1, m_wdata=0x12345678 held GRANT..DONE, d_ready at t+6, d_rdata unchanged.
- Simultaneous requests, macro undefined: both strobes at t -> D is served first (d_ready at t+6). I then gets m_strobe at t+8 and i_ready at t+13.
- Same stimulus with MEM_ARB_RR_EN, after a prior D grant -> I is served first, then D.
- Reset asserted during WAIT cycle 2 -> next cycle IDLE, all outputs 0, no ready pulse. A new i_strobe afterwards completes normally.
- Back-to-back I-cache reads with strobe dropped after each ready and re-raised in the following IDLE -> m_strobe pulses spaced exactly WAIT_CYCLES+3 cycles apart; no duplicate ready pulses.
